// File: rtl/sma_window_decoder.sv
// Window-sum decoder: recovers samples x[n] = s[n] - (x[n-1]+...+x[n-TAPS+1])
// from full-precision moving sums, with saturation, sticky overflow and valid/ready on both sides.
module sma_window_decoder #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 4,
  parameter int SUM_W  = DATA_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SUM_W-1:0]  sum_in,
  input  logic                     sum_valid,
  output logic                     sum_ready,
  input  logic                     resync,
  output logic signed [DATA_W-1:0] x_out,
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic                     overflow,
  output logic [15:0]              sample_cnt
);

  localparam int HW = TAPS - 1;
  localparam int RW = SUM_W + 1;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (DATA_W - 1)));

  // hist_q[0] is the most recently recovered sample, x[n-1].
  logic signed [DATA_W-1:0] hist_q [HW];
  logic signed [DATA_W-1:0] hist_d [HW];
  logic signed [DATA_W-1:0] x_q, x_d;
  logic                     x_valid_q, x_valid_d;
  logic                     overflow_q, overflow_d;
  logic [15:0]              cnt_q, cnt_d;

  logic signed [RW-1:0]     hist_sum;
  logic signed [RW-1:0]     resid;
  logic signed [DATA_W-1:0] x_sat;
  logic                     sat_hit;
  logic                     accept;

  // Reset gates ready so nothing is accepted while the decoder is held in reset.
  assign sum_ready = rst && !resync && (!x_valid_q || x_ready);
  assign accept    = sum_valid && sum_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    hist_sum = '0;
    for (int i = 0; i < HW; i++) begin
      hist_sum = hist_sum + RW'(hist_q[i]);
    end
    resid   = RW'(sum_in) - hist_sum;
    sat_hit = 1'b0;
    x_sat   = resid[DATA_W-1:0];
    if (resid > SAT_MAX) begin
      x_sat   = SAT_MAX[DATA_W-1:0];
      sat_hit = 1'b1;
    end else if (resid < SAT_MIN) begin
      x_sat   = SAT_MIN[DATA_W-1:0];
      sat_hit = 1'b1;
    end
  end

  always_comb begin
    x_d        = x_q;
    x_valid_d  = x_valid_q;
    overflow_d = overflow_q;
    cnt_d      = cnt_q;
    hist_d     = hist_q;
    if (accept) begin
      x_d        = x_sat;
      x_valid_d  = 1'b1;
      overflow_d = overflow_q | sat_hit;
      cnt_d      = cnt_q + 16'd1;
      // The saturated value enters history so later outputs stay consistent with what was delivered.
      hist_d[0]  = x_sat;
      for (int i = 1; i < HW; i++) begin
        hist_d[i] = hist_q[i-1];
      end
    end else if (x_ready) begin
      x_valid_d = 1'b0;
    end
    // Resync never coincides with an accept; a pending output is left to drain normally.
    if (resync) begin
      for (int i = 0; i < HW; i++) begin
        hist_d[i] = '0;
      end
      cnt_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      // NOTE: the history array is tiny and must start at zero to match the encoder, so it is reset like any register.
      for (int i = 0; i < HW; i++) begin
        hist_q[i] <= '0;
      end
      x_q        <= '0;
      x_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hist_q     <= hist_d;
      x_q        <= x_d;
      x_valid_q  <= x_valid_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign x_out      = x_q;
  assign x_valid    = x_valid_q;
  assign overflow   = overflow_q;
  assign sample_cnt = cnt_q;

endmodule
